// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared control-bundle types, forward selects and ALU op codes
package mips_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] alu_control;
    } ctrl_e_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
    } ctrl_m_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } ctrl_w_t;

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - pipeline register with synchronous reset and synchronous clear
// Ports: clk, reset (sync, active-high), clear_i (sync bubble insert),
//        d_i [W-1:0] next contents, q_o [W-1:0] registered contents.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            q_q <= '0;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// rtl/hazard_pipe_ctrl.sv - control carrier D->E->M->W plus forwarding/stall/flush unit
// Ports: clk, reset (sync, active-high); D-stage controls, pcSrcD and rsD/rtD/rdD in;
//        E/M/W control bundles, rsE/rtE/rdE, writeReg{E,M,W} out;
//        forwardAE/BE (2b), forwardAD/BD, stallF, stallD, flushE, flushD out.
module hazard_pipe_ctrl
    import mips_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          regWriteD,
    input  logic          memToRegD,
    input  logic          memWriteD,
    input  logic          aluSrcD,
    input  logic          regDstD,
    input  logic          branchD,
    input  logic          jumpD,
    input  logic [2:0]    aluControlD,
    input  logic          pcSrcD,
    input  logic [RW-1:0] rsD,
    input  logic [RW-1:0] rtD,
    input  logic [RW-1:0] rdD,
    output logic          regWriteE,
    output logic          memToRegE,
    output logic          memWriteE,
    output logic          aluSrcE,
    output logic          regDstE,
    output logic [2:0]    aluControlE,
    output logic [RW-1:0] rsE,
    output logic [RW-1:0] rtE,
    output logic [RW-1:0] rdE,
    output logic [RW-1:0] writeRegE,
    output logic [RW-1:0] writeRegM,
    output logic [RW-1:0] writeRegW,
    output logic          regWriteM,
    output logic          memToRegM,
    output logic          memWriteM,
    output logic          regWriteW,
    output logic          memToRegW,
    output logic [1:0]    forwardAE,
    output logic [1:0]    forwardBE,
    output logic          forwardAD,
    output logic          forwardBD,
    output logic          stallF,
    output logic          stallD,
    output logic          flushE,
    output logic          flushD
);

    localparam int EW = $bits(ctrl_e_t) + 3 * RW;
    localparam int MW = $bits(ctrl_m_t) + RW;
    localparam int WW = $bits(ctrl_w_t) + RW;

    ctrl_e_t ctrl_d;
    ctrl_e_t ctrl_e_q;
    ctrl_m_t ctrl_m_q;
    ctrl_w_t ctrl_w_q;
    logic [EW-1:0] e_q;
    logic [MW-1:0] m_q;
    logic [WW-1:0] w_q;
    logic lwstall;
    logic branchstall;

    assign ctrl_d = '{reg_write: regWriteD, mem_to_reg: memToRegD, mem_write: memWriteD,
                      alu_src: aluSrcD, reg_dst: regDstD, alu_control: aluControlD};

    // E is the only stage that takes bubbles; M and W are free-running.
    pipe_reg #(.W(EW)) u_e_reg (
        .clk(clk), .reset(reset), .clear_i(flushE),
        .d_i({ctrl_d, rsD, rtD, rdD}), .q_o(e_q)
    );
    pipe_reg #(.W(MW)) u_m_reg (
        .clk(clk), .reset(reset), .clear_i(1'b0),
        .d_i({ctrl_e_q.reg_write, ctrl_e_q.mem_to_reg, ctrl_e_q.mem_write, writeRegE}),
        .q_o(m_q)
    );
    pipe_reg #(.W(WW)) u_w_reg (
        .clk(clk), .reset(reset), .clear_i(1'b0),
        .d_i({ctrl_m_q.reg_write, ctrl_m_q.mem_to_reg, writeRegM}),
        .q_o(w_q)
    );

    assign {ctrl_e_q, rsE, rtE, rdE} = e_q;
    assign {ctrl_m_q, writeRegM}     = m_q;
    assign {ctrl_w_q, writeRegW}     = w_q;

    assign regWriteE   = ctrl_e_q.reg_write;
    assign memToRegE   = ctrl_e_q.mem_to_reg;
    assign memWriteE   = ctrl_e_q.mem_write;
    assign aluSrcE     = ctrl_e_q.alu_src;
    assign regDstE     = ctrl_e_q.reg_dst;
    assign aluControlE = ctrl_e_q.alu_control;
    assign regWriteM   = ctrl_m_q.reg_write;
    assign memToRegM   = ctrl_m_q.mem_to_reg;
    assign memWriteM   = ctrl_m_q.mem_write;
    assign regWriteW   = ctrl_w_q.reg_write;
    assign memToRegW   = ctrl_w_q.mem_to_reg;

    assign writeRegE = ctrl_e_q.reg_dst ? rdE : rtE;

    always_comb begin
        forwardAE = FWD_RF;
        if (rsE != '0 && regWriteM && rsE == writeRegM) begin
            forwardAE = FWD_M;
        end else if (rsE != '0 && regWriteW && rsE == writeRegW) begin
            forwardAE = FWD_W;
        end

        forwardBE = FWD_RF;
        if (rtE != '0 && regWriteM && rtE == writeRegM) begin
            forwardBE = FWD_M;
        end else if (rtE != '0 && regWriteW && rtE == writeRegW) begin
            forwardBE = FWD_W;
        end

        forwardAD = (rsD != '0) && regWriteM && (rsD == writeRegM);
        forwardBD = (rtD != '0) && regWriteM && (rtD == writeRegM);

        // Deliberately no $0 exemption on the load-use check: a spare stall is harmless.
        lwstall = memToRegE && (rtE == rsD || rtE == rtD);
        branchstall = branchD &&
            ((regWriteE && (writeRegE == rsD || writeRegE == rtD)) ||
             (memToRegM && (writeRegM == rsD || writeRegM == rtD)));

        stallF = lwstall || branchstall;
        stallD = lwstall || branchstall;
        flushE = lwstall || branchstall;
        // A stalled branch is re-evaluated next cycle, so its redirect must not flush D yet.
        flushD = (pcSrcD || jumpD) && !(lwstall || branchstall);
    end

endmodule
